alu_multiword_seq: RTL

//   Sequencer that runs one ALU operation over a multi-word operand (1..2^p_addr_width words), LSW first.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_multiword_seq_alu.sv | 66 ++++++
 rtl/alu_multiword_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-word ALU sequencer and its word ALU.
package alu_pkg;

  // ALU opcodes
  localparam logic [3:0] OpAdc  = 4'd0;
  localparam logic [3:0] OpSbb1 = 4'd1;  // op1 - op2 - borrow
  localparam logic [3:0] OpSbb2 = 4'd2;  // op2 - op1 - borrow
  localparam logic [3:0] OpNot  = 4'd3;
  localparam logic [3:0] OpAnd  = 4'd4;
  localparam logic [3:0] OpOr   = 4'd5;
  localparam logic [3:0] OpXor  = 4'd6;
  localparam logic [3:0] OpShl  = 4'd7;
  localparam logic [3:0] OpShr  = 4'd8;
  localparam logic [3:0] OpSar  = 4'd9;

  // Flag vector bit positions {P,S,Z,V,C}
  localparam int unsigned FlagC = 0;
  localparam int unsigned FlagV = 1;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagS = 3;
  localparam int unsigned FlagP = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StExec,
    StDone
  } seq_state_e;

  // Shifts cannot be chained word-by-word through the carry alone, so the
  // sequencer only accepts the arithmetic and bitwise opcodes.
  function automatic logic op_supported(input logic [3:0] op);
    return (op <= OpXor);
  endfunction

endpackage

// File: rtl/alu_multiword_seq_alu.sv
// Single-word combinational ALU used by the multi-word sequencer.
module alu_multiword_seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned p_data_width  = 16,
  parameter int unsigned p_flags_width = 5
) (
  input  logic [3:0]               opcode_i,
  input  logic [p_data_width-1:0]  op1_i,
  input  logic [p_data_width-1:0]  op2_i,
  input  logic                     carry_i,
  input  logic                     oe_i,
  output logic [p_data_width-1:0]  result_o,
  output logic [p_flags_width-1:0] flags_o
);

  localparam int unsigned Msb = p_data_width - 1;

  logic [p_data_width:0]   ext_a, ext_b, ext_c, wide;
  logic [p_data_width-1:0] res;
  logic                    c, v;

  // Word result plus carry/borrow, overflow, zero, sign and even parity
  always_comb begin
    ext_a = {1'b0, op1_i};
    ext_b = {1'b0, op2_i};
    ext_c = {{p_data_width{1'b0}}, carry_i};
    wide  = '0;
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    case (opcode_i)
      OpAdc: begin
        wide = ext_a + ext_b + ext_c;
        res  = wide[Msb:0];
        c    = wide[p_data_width];
        v    = (op1_i[Msb] == op2_i[Msb]) && (res[Msb] != op1_i[Msb]);
      end
      OpSbb1: begin
        wide = ext_a - ext_b - ext_c;
        res  = wide[Msb:0];
        c    = wide[p_data_width];
        v    = (op1_i[Msb] != op2_i[Msb]) && (res[Msb] != op1_i[Msb]);
      end
      OpSbb2: begin
        wide = ext_b - ext_a - ext_c;
        res  = wide[Msb:0];
        c    = wide[p_data_width];
        v    = (op2_i[Msb] != op1_i[Msb]) && (res[Msb] != op2_i[Msb]);
      end
      OpNot:   res = ~op1_i;
      OpAnd:   res = op1_i & op2_i;
      OpOr:    res = op1_i | op2_i;
      OpXor:   res = op1_i ^ op2_i;
      default: res = '0;
    endcase
    result_o       = oe_i ? res : '0;
    flags_o        = '0;
    flags_o[FlagC] = c;
    flags_o[FlagV] = v;
    flags_o[FlagZ] = (res == '0);
    flags_o[FlagS] = res[Msb];
    flags_o[FlagP] = ~^res;
  end

endmodule

// File: rtl/alu_multiword_seq.sv
// Runs one ALU operation across a multi-word operand, LSW first, chaining
// carry between words and merging the per-word flags.
module alu_multiword_seq
  import alu_pkg::*;
#(
  parameter int unsigned p_data_width  = 16,
  parameter int unsigned p_flags_width = 5,
  parameter int unsigned p_addr_width  = 4
) (
  input  logic                     i_w_clk,
  input  logic                     i_w_rst_n,
  input  logic                     i_w_start,
  input  logic [3:0]               i_w_opcode,
  input  logic [p_addr_width-1:0]  i_w_last_idx,
  input  logic                     i_w_carry_in,
  input  logic                     i_w_abort,
  output logic                     o_w_rd_en,
  output logic [p_addr_width-1:0]  o_w_rd_addr,
  input  logic [p_data_width-1:0]  i_w_rd_op1,
  input  logic [p_data_width-1:0]  i_w_rd_op2,
  output logic                     o_w_wr_en,
  output logic [p_addr_width-1:0]  o_w_wr_addr,
  output logic [p_data_width-1:0]  o_w_wr_data,
  output logic                     o_w_busy,
  output logic                     o_w_done,
  output logic                     o_w_err,
  output logic [p_flags_width-1:0] o_w_flags
);

  seq_state_e state_q, state_d;

  logic [3:0]               op_q;
  logic [p_addr_width-1:0]  last_q;
  logic [p_addr_width-1:0]  idx_q;
  logic                     carry_q;
  logic                     zacc_q;
  logic                     err_q;
  logic [p_flags_width-1:0] flags_q;

  logic                     accept;
  logic                     is_last;
  logic [p_data_width-1:0]  alu_result;
  logic [p_flags_width-1:0] alu_flags;
  logic [p_flags_width-1:0] final_flags;

  alu_multiword_seq_alu #(
    .p_data_width (p_data_width),
    .p_flags_width(p_flags_width)
  ) u_alu (
    .opcode_i(op_q),
    .op1_i   (i_w_rd_op1),
    .op2_i   (i_w_rd_op2),
    .carry_i (carry_q),
    .oe_i    (1'b1),
    .result_o(alu_result),
    .flags_o (alu_flags)
  );

  assign accept  = (state_q == StIdle) && i_w_start;
  assign is_last = (idx_q == last_q);

  // Z must hold across every word; the other flags come from the top word
  always_comb begin
    final_flags        = alu_flags;
    final_flags[FlagZ] = zacc_q & alu_flags[FlagZ];
  end

  // Next-state: unsupported opcodes skip straight to DONE to report err
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_w_start) begin
          state_d = op_supported(i_w_opcode) ? StRead : StDone;
        end
      end
      StRead:  state_d = i_w_abort ? StIdle : StExec;
      StExec: begin
        if (i_w_abort)    state_d = StIdle;
        else if (is_last) state_d = StDone;
        else              state_d = StRead;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) state_q <= StIdle;
    else            state_q <= state_d;
  end

  // Operation latches, word index, carry chain and flag accumulation
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      op_q    <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      err_q   <= 1'b0;
      flags_q <= '0;
    end else if (accept) begin
      op_q    <= i_w_opcode;
      last_q  <= i_w_last_idx;
      idx_q   <= '0;
      carry_q <= i_w_carry_in;
      zacc_q  <= 1'b1;
      err_q   <= ~op_supported(i_w_opcode);
    end else if ((state_q == StExec) && !i_w_abort) begin
      carry_q <= alu_flags[FlagC];
      zacc_q  <= zacc_q & alu_flags[FlagZ];
      if (is_last) flags_q <= final_flags;
      else         idx_q   <= idx_q + 1'b1;
    end
  end

  // Strobes and buses decoded from state; abort suppresses the write
  always_comb begin
    o_w_rd_en   = (state_q == StRead);
    o_w_rd_addr = o_w_rd_en ? idx_q : '0;
    o_w_wr_en   = (state_q == StExec) && !i_w_abort;
    o_w_wr_addr = o_w_wr_en ? idx_q : '0;
    o_w_wr_data = o_w_wr_en ? alu_result : '0;
    o_w_busy    = (state_q == StRead) || (state_q == StExec);
    o_w_done    = (state_q == StDone);
    o_w_err     = err_q;
    o_w_flags   = flags_q;
  end

endmodule
